// File: rtl/usr_shift_seq.sv
// Sequencer that loads a parallel word into a universal shift register and then shifts it out
// serially. Optional feature: define USR_SHIFT_SEQ_PAUSE_EN to add a pause input for SHIFT.
module usr_shift_seq #(
    parameter int unsigned WIDTH    = 4,
    parameter logic        FILL_BIT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
`ifdef USR_SHIFT_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic [1:0]       MODE,
    output logic [WIDTH-1:0] DATAIN,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic              dir_q, dir_d;
    logic              ready_q, ready_d;
    logic [1:0]        mode_q, mode_d;
    logic [WIDTH-1:0]  datain_q, datain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              shift_go;

`ifdef USR_SHIFT_SEQ_PAUSE_EN
    assign shift_go = ~pause;
`else
    assign shift_go = 1'b1;
`endif

    // Pin outputs are decoded from the current state and registered, so each pin value is
    // presented during the cycle that ends on the edge where the shift register acts on it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        dir_d    = dir_q;
        mode_d   = 2'b00;
        datain_d = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid && ready_q) begin
                    word_d  = in_data;
                    dir_d   = in_dir;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                mode_d   = 2'b11;
                datain_d = word_q;
                busy_d   = 1'b1;
                cnt_d    = '0;
                state_d  = StShift;
            end
            StShift: begin
                busy_d   = 1'b1;
                datain_d = {{(WIDTH-1){1'b0}}, FILL_BIT};
                if (shift_go) begin
                    mode_d = dir_q ? 2'b01 : 2'b10;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            word_q   <= '0;
            dir_q    <= 1'b0;
            ready_q  <= 1'b0;
            mode_q   <= 2'b00;
            datain_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            dir_q    <= dir_d;
            ready_q  <= ready_d;
            mode_q   <= mode_d;
            datain_q <= datain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign in_ready = ready_q;
    assign MODE     = mode_q;
    assign DATAIN   = datain_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_usr_shift_seq.sv
// Directed bench for usr_shift_seq with a behavioural 4-bit universal shift register
// attached to MODE/DATAIN. Pause scenario runs only when USR_SHIFT_SEQ_PAUSE_EN is defined.
module tb_usr_shift_seq;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_dir;
    logic       pause;
    logic [1:0] MODE;
    logic [3:0] DATAIN;
    logic       busy;
    logic       done;
    logic [3:0] sr;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] words [3] = '{4'b1001, 4'b0101, 4'b1110};
    logic       dirs  [3] = '{1'b0, 1'b1, 1'b0};

    usr_shift_seq #(
        .WIDTH    (4),
        .FILL_BIT (1'b0)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dir   (in_dir),
`ifdef USR_SHIFT_SEQ_PAUSE_EN
        .pause    (pause),
`endif
        .MODE     (MODE),
        .DATAIN   (DATAIN),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Downstream universal shift register; serial input is DATAIN[0] in both directions.
    always @(posedge clock) begin
        case (MODE)
            2'b11:   sr <= DATAIN;
            2'b10:   sr <= {sr[2:0], DATAIN[0]};
            2'b01:   sr <= {DATAIN[0], sr[3:1]};
            default: sr <= sr;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one word and let the next edge accept it.
    task automatic send(input logic [3:0] data, input logic dir);
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        in_dir   = dir;
        tick();
        in_valid = 1'b0;
        in_data  = ~data;
        in_dir   = ~dir;
    endtask

    // Follow one word after its accept edge until done, with an optional pause window.
    task automatic watch(input int ps, input int pl, output int lat, output int n_load,
                         output int n_left, output int n_right, output int n_hold,
                         output logic [3:0] ld, output logic [3:0] sr_done);
        lat = -1; n_load = 0; n_left = 0; n_right = 0; n_hold = 0;
        ld = 4'hx; sr_done = 4'hx;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (MODE == 2'b11) begin
                n_load++;
                ld = DATAIN;
            end
            if (MODE == 2'b10) n_left++;
            if (MODE == 2'b01) n_right++;
            if (MODE == 2'b00 && n_load > 0 && !done) n_hold++;
            pause = (ps != 0 && k >= ps && k < ps + pl);
            if (done) begin
                lat = k;
                sr_done = sr;
                break;
            end
        end
        pause = 1'b0;
    endtask

    int         lat, n_load, n_left, n_right, n_hold, nacc, overlap, n_done;
    int         acc_cyc [3];
    logic [3:0] ld, sr_done;
    logic       acc;
    logic [3:0] loaded [$];
    logic [1:0] exp_mode [7] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    logic [3:0] exp_sr   [7] = '{4'hx, 4'b1011, 4'b0110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; pause = 1'b0;
        #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_mode", 32'(MODE), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick(); tick();
        #2 reset = 1'b0;
        tick();
        check("ready_after_release", 32'(in_ready), 32'd1);

        // Asynchronous reset asserted between edges.
        #2 reset = 1'b1;
        #1;
        check("async_ready", 32'(in_ready), 32'd0);
        check("async_mode", 32'(MODE), 32'd0);
        tick();
        #2 reset = 1'b0;
        tick();
        check("ready_after_release2", 32'(in_ready), 32'd1);

        // Left word, cycle by cycle.
        send(4'b1011, 1'b0);
        check("l_ready_after_accept", 32'(in_ready), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("l_mode_k%0d", k), 32'(MODE), 32'(exp_mode[k-1]));
            if (k == 1) begin
                check("l_load_data", 32'(DATAIN), 32'b1011);
                check("l_load_busy", 32'(busy), 32'd1);
            end else begin
                check($sformatf("l_sr_k%0d", k), 32'(sr), 32'(exp_sr[k-1]));
            end
            if (k >= 2 && k <= 5) check($sformatf("l_fill_k%0d", k), 32'(DATAIN), 32'd0);
            check($sformatf("l_done_k%0d", k), 32'(done), (k == 6) ? 32'd1 : 32'd0);
            check($sformatf("l_busy_k%0d", k), 32'(busy), (k <= 6) ? 32'd1 : 32'd0);
            check($sformatf("l_ready_k%0d", k), 32'(in_ready), (k >= 6) ? 32'd1 : 32'd0);
        end

        // Right word.
        send(4'b0110, 1'b1);
        watch(0, 0, lat, n_load, n_left, n_right, n_hold, ld, sr_done);
        check("r_done_latency", 32'(lat), 32'd6);
        check("r_load_cycles", 32'(n_load), 32'd1);
        check("r_load_data", 32'(ld), 32'b0110);
        check("r_right_cycles", 32'(n_right), 32'd4);
        check("r_left_cycles", 32'(n_left), 32'd0);
        check("r_sr_done", 32'(sr_done), 32'b0000);
        tick();

        // Back-to-back with in_valid held high.
        in_valid = 1'b1; in_data = words[0]; in_dir = dirs[0];
        nacc = 0; overlap = 0;
        for (int c = 0; c < 60; c++) begin
            acc = in_valid && in_ready;
            if (acc) begin
                acc_cyc[nacc] = c;
                nacc++;
            end
            tick();
            if (acc) begin
                if (nacc < 3) begin
                    in_data = words[nacc];
                    in_dir  = dirs[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (in_ready && MODE != 2'b00) overlap++;
            if (MODE == 2'b11) loaded.push_back(DATAIN);
            if (nacc == 3 && done) break;
        end
        in_valid = 1'b0;
        check("b2b_accepts", 32'(nacc), 32'd3);
        check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd7);
        check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd7);
        check("b2b_ready_overlap", 32'(overlap), 32'd0);
        check("b2b_loads", 32'(loaded.size()), 32'd3);
        for (int i = 0; i < 3 && i < loaded.size(); i++)
            check($sformatf("b2b_word%0d", i), 32'(loaded[i]), 32'(words[i]));
        tick(); tick();

        // Abort in the second SHIFT cycle.
        send(4'b1011, 1'b0);
        tick(); tick(); tick();
        check("abort_pre_mode", 32'(MODE), 32'b10);
        #2 reset = 1'b1;
        #1;
        check("abort_mode", 32'(MODE), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        send(4'b0110, 1'b1);
        watch(0, 0, lat, n_load, n_left, n_right, n_hold, ld, sr_done);
        check("post_abort_latency", 32'(lat), 32'd6);
        check("post_abort_load", 32'(ld), 32'b0110);
        check("post_abort_right", 32'(n_right), 32'd4);
        check("post_abort_sr", 32'(sr_done), 32'b0000);
        tick();

`ifdef USR_SHIFT_SEQ_PAUSE_EN
        send(4'b1011, 1'b0);
        watch(3, 3, lat, n_load, n_left, n_right, n_hold, ld, sr_done);
        check("pause_latency", 32'(lat), 32'd9);
        check("pause_left_cycles", 32'(n_left), 32'd4);
        check("pause_hold_cycles", 32'(n_hold), 32'd3);
        check("pause_sr_done", 32'(sr_done), 32'b0000);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
